// File: rtl/mandel_pkg.sv
// mandel_pkg: shared widths, fixed-point type, FSM states and radius constants for the Mandelbrot engine
package mandel_pkg;
  localparam int WIDTH = 32;
  localparam int FRAC = 28;
  localparam int ITER_W = 8;
  typedef logic signed [WIDTH-1:0] fx_t;
  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
  localparam fx_t FX_ONE = fx_t'(64'd1 << FRAC);
  localparam logic signed [WIDTH:0] ESCAPE_R2 = (WIDTH+1)'(64'd4 << FRAC);
  localparam logic signed [WIDTH:0] BULB_R2 = (WIDTH+1)'(64'd1 << (FRAC - 4));
endpackage

// File: rtl/fx_mul.sv
// fx_mul: signed fixed-point multiply, full-width product shifted by FRAC and truncated, with overflow flag
module fx_mul #(
  parameter int WIDTH = mandel_pkg::WIDTH,
  parameter int FRAC = mandel_pkg::FRAC
) (
  input  logic signed [WIDTH-1:0] x,
  input  logic signed [WIDTH-1:0] y,
  output logic signed [WIDTH-1:0] p,
  output logic                    ovf
);
  logic signed [2*WIDTH-1:0] full, sh;
  assign full = x * y;
  assign sh = full >>> FRAC;
  assign p = WIDTH'(sh);
  assign ovf = sh != (2*WIDTH)'(p);
endmodule

// File: rtl/mandel_iter_engine.sv
// mandel_iter_engine: Mandelbrot escape-time iterator, one z update per cycle; MANDEL_BULB_CHECK_EN adds a period-2 bulb shortcut
module mandel_iter_engine #(
  parameter int WIDTH = mandel_pkg::WIDTH,
  parameter int FRAC = mandel_pkg::FRAC,
  parameter int ITER_W = mandel_pkg::ITER_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic [9:0]              x_in,
  input  logic [9:0]              y_in,
  input  logic [ITER_W-1:0]       max_iter,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ITER_W-1:0]       count_out,
  output logic [9:0]              x_out,
  output logic [9:0]              y_out,
  output logic                    busy
);
  import mandel_pkg::*;
  state_t state;
  logic signed [WIDTH-1:0] zr, zi, ar, br, zr2, zi2, zri;
  logic signed [WIDTH:0] mag;
  logic ovf_rr, ovf_ii, ovf_ri, stop, in_bulb;
  logic [ITER_W-1:0] n, mi;
  logic [9:0] xr, yr;
  fx_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_rr (.x(zr), .y(zr), .p(zr2), .ovf(ovf_rr));
  fx_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_ii (.x(zi), .y(zi), .p(zi2), .ovf(ovf_ii));
  fx_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_ri (.x(zr), .y(zi), .p(zri), .ovf(ovf_ri));
  assign mag = (WIDTH+1)'(zr2) + (WIDTH+1)'(zi2);
  // any product that overflows the fixed-point range is at least 8.0, so z is already outside radius 2
  assign stop = ovf_rr || ovf_ii || ovf_ri || mag > ESCAPE_R2 || n == mi;
`ifdef MANDEL_BULB_CHECK_EN
  logic signed [WIDTH-1:0] ap1, aa2, bb2;
  logic signed [WIDTH:0] bsum;
  logic ovf_aa, ovf_bb;
  assign ap1 = ar + FX_ONE;
  fx_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_aa (.x(ap1), .y(ap1), .p(aa2), .ovf(ovf_aa));
  fx_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_bb (.x(br), .y(br), .p(bb2), .ovf(ovf_bb));
  assign bsum = (WIDTH+1)'(aa2) + (WIDTH+1)'(bb2);
  assign in_bulb = n == '0 && !ovf_aa && !ovf_bb && bsum < BULB_R2;
`else
  assign in_bulb = 1'b0;
`endif
  assign in_ready = state == IDLE && !rst;
  assign out_valid = state == DONE && !rst;
  assign busy = state != IDLE && !rst;
  assign x_out = xr;
  assign y_out = yr;
  // accept a point, iterate until escape or limit, then hold the result until taken
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      zr <= '0;
      zi <= '0;
      ar <= '0;
      br <= '0;
      n <= '0;
      mi <= '0;
      xr <= '0;
      yr <= '0;
      count_out <= '0;
    end else if (state == IDLE && in_valid) begin
      ar <= a;
      br <= b;
      xr <= x_in;
      yr <= y_in;
      mi <= max_iter;
      zr <= '0;
      zi <= '0;
      n <= '0;
      state <= ITER;
    end else if (state == ITER) begin
      if (in_bulb || stop) begin
        count_out <= in_bulb ? mi : n;
        state <= DONE;
      end else begin
        zr <= zr2 - zi2 + ar;
        zi <= (zri <<< 1) + br;
        n <= n + 1'b1;
      end
    end else if (state == DONE && out_ready) begin
      state <= IDLE;
    end
  end
endmodule

// File: doc/mandel_iter_engine.md
MANDEL_ITER_ENGINE -- requirements
Module: mandel_iter_engine

Interface
REQ-001 Parameter WIDTH, 32, signed fixed-point width of the a/b coordinates and of the z registers.
REQ-002 Parameter FRAC, 28, number of fractional bits (Q4.28).
REQ-003 Parameter ITER_W, 8, width of the iteration counter and of max_iter.
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  coordinate pair valid from the mapper.
REQ-007 in_ready  out  1  engine can accept a coordinate pair.
REQ-008 a  in  WIDTH  real part of c, signed Q4.28.
REQ-009 b  in  WIDTH  imaginary part of c, signed Q4.28.
REQ-010 x_in  in  10  pixel column tag; y_in  in  10  pixel row tag.
REQ-011 max_iter  in  ITER_W  iteration limit, sampled on accept.
REQ-012 out_valid  out  1  result valid toward the RAM write port.
REQ-013 out_ready  in  1  consumer accepts the result.
REQ-014 count_out  out  ITER_W  escape count; x_out  out  10, y_out  out  10  tags for the RAM write address {y,x}.
REQ-015 busy  out  1  high whenever the state is not IDLE.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, ITER, DONE.
REQ-017 in_ready SHALL be high only in IDLE; a transfer occurs on an edge where in_valid and in_ready are both high.
REQ-018 On accept: latch a, b, x_in, y_in and max_iter; clear zr, zi and n to 0; go to ITER.
REQ-019 Each ITER cycle SHALL evaluate the current z: if zr^2+zi^2 > 4.0 or n == max_iter, go to DONE with count_out = n; otherwise update zr <= zr^2 - zi^2 + a, zi <= 2*zr*zi + b, n <= n+1.
REQ-020 Each product SHALL be formed at 2*WIDTH bits, arithmetic-shifted right by FRAC and truncated to WIDTH bits. The magnitude sum and the compare against 4.0 SHALL use WIDTH+1 bits so the sum cannot wrap.
REQ-021 Throughput SHALL be one iteration per cycle. With the accept edge as cycle 0 and escape detected at n = k, out_valid SHALL rise in cycle k+2.
REQ-022 In DONE, out_valid, count_out, x_out and y_out SHALL hold stable until out_ready is high. On that edge the FSM returns to IDLE, so in_ready rises one cycle later; there is no same-cycle back-to-back accept.
REQ-023 With max_iter = 0, count_out SHALL be 0 and out_valid SHALL rise in cycle 2.
REQ-024 A point that never escapes SHALL report count_out = max_iter.
REQ-025 in_valid SHALL be ignored outside IDLE; out_ready SHALL be ignored outside DONE.

Reset
REQ-026 While rst is high: state = IDLE; out_valid = 0; in_ready = 0; busy = 0; count_out, x_out, y_out, zr, zi and n = 0.
REQ-027 A reset asserted in ITER or DONE SHALL discard the pending result with no output transfer. in_ready SHALL be high in the first cycle after rst falls.

Configuration
REQ-028 Macro MANDEL_BULB_CHECK_EN, when defined, SHALL add a test in the first ITER cycle (n = 0): if (a+1.0)^2 + b^2 < 1/16, go directly to DONE with count_out = max_iter.
REQ-029 Without MANDEL_BULB_CHECK_EN, no such test exists and every point iterates per REQ-019.

Structure
REQ-030 Package mandel_pkg SHALL hold WIDTH, FRAC, ITER_W, the fixed-point typedef, the state enum, ESCAPE_R2 (4.0 in Q4.28) and BULB_R2 (1/16 in Q4.28).
REQ-031 Sub-module fx_mul SHALL perform the signed WIDTH x WIDTH multiply with the FRAC shift. It is instantiated once per product: zr^2, zi^2, zr*zi, and the bulb squares when enabled.

Verification
REQ-032 c = (0,0), max_iter = 20, out_ready = 1 -> count_out = 20, out_valid in cycle 22, tags echoed.
REQ-033 c = (3.0,0), max_iter = 20 -> count_out = 1, out_valid in cycle 3.
REQ-034 c = (0.5,0.5), max_iter = 50, out_ready held low 5 cycles after out_valid -> outputs stable throughout, in_ready rises the cycle after the out_ready edge.
REQ-035 c = (-1.0,0), max_iter = 100 -> with MANDEL_BULB_CHECK_EN: count_out = 100, out_valid in cycle 2; without it: count_out = 100, out_valid in cycle 102.
REQ-036 rst pulsed in the 10th ITER cycle -> no out_valid, all outputs 0, next accepted pair computes correctly.
REQ-037 max_iter = 0, any c -> count_out = 0, out_valid in cycle 2.
